// File: rtl/noc_vc_link_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_link_scheduler_pkg
// Purpose  : Shared constants for the NoC virtual-channel link scheduler.
// Contents : STAT_W - width of the optional per-VC statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
package noc_vc_link_scheduler_pkg;

  localparam int STAT_W = 32;

endpackage : noc_vc_link_scheduler_pkg
`default_nettype wire

// File: rtl/noc_vc_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_rr_select
// Purpose  : Combinational round-robin selector. Returns the first asserted
//            request strictly after i_ptr, wrapping modulo N.
// Ports    : i_req   [N-1:0] request vector
//            i_ptr   [W-1:0] index of the last served requester
//            o_idx   [W-1:0] selected index (0 when nothing selected)
//            o_valid         a request was selected
// Revision : 1.0 - initial release
// ============================================================================
module noc_vc_rr_select #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  logic [W-1:0] w_hi_idx;
  logic         w_hi_found;
  logic [W-1:0] w_lo_idx;
  logic         w_lo_found;

  // The rotated search is split into two ascending scans: indices above the
  // pointer first, then the wrapped part from 0 up to the pointer itself.
  always_comb begin
    w_hi_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_idx   = '0;
    w_lo_found = 1'b0;
    for (int v = 0; v < N; v++) begin
      if (i_req[v] && (v > int'(i_ptr)) && !w_hi_found) begin
        w_hi_idx   = W'(v);
        w_hi_found = 1'b1;
      end
      if (i_req[v] && (v <= int'(i_ptr)) && !w_lo_found) begin
        w_lo_idx   = W'(v);
        w_lo_found = 1'b1;
      end
    end
  end

  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_valid = w_hi_found | w_lo_found;

endmodule : noc_vc_rr_select
`default_nettype wire

// File: rtl/noc_vc_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_link_scheduler
// Purpose  : Shares one physical NoC link among VCHANNELS virtual channels.
//            Zero-latency round-robin grant with a soft per-packet lock that
//            is bounded by QUANTUM flits.
// Ports    : clk, rst            clock, synchronous active-high reset
//            in_flit/in_last     per-VC flit payload and last marker
//            in_valid/in_ready   per-VC source handshake
//            out_flit/out_last   link payload (granted VC, zero when idle)
//            out_valid/out_ready per-VC link handshake (out_valid one-hot)
//            lock_active/lock_vc lock state for trace/debug
// Options  : NOC_VC_SCHED_STATS_EN adds stat_clr, stat_flits, stat_stall.
// Revision : 1.0 - initial release
// ============================================================================
module noc_vc_link_scheduler
  import noc_vc_link_scheduler_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 2,
  parameter int QUANTUM    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [VCHANNELS*FLIT_WIDTH-1:0]   in_flit,
  input  logic [VCHANNELS-1:0]              in_last,
  input  logic [VCHANNELS-1:0]              in_valid,
  output logic [VCHANNELS-1:0]              in_ready,
  output logic [FLIT_WIDTH-1:0]             out_flit,
  output logic                              out_last,
  output logic [VCHANNELS-1:0]              out_valid,
  input  logic [VCHANNELS-1:0]              out_ready,
  output logic                              lock_active,
  output logic [((VCHANNELS > 1) ? $clog2(VCHANNELS) : 1)-1:0] lock_vc
`ifdef NOC_VC_SCHED_STATS_EN
  ,
  input  logic                              stat_clr,
  output logic [VCHANNELS*STAT_W-1:0]       stat_flits,
  output logic [VCHANNELS*STAT_W-1:0]       stat_stall
`endif
);

  localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
  localparam int CW = $clog2(QUANTUM + 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]           r_state;
  logic [VW-1:0]        r_lock_vc;
  logic [VW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_cnt;

  logic [VCHANNELS-1:0] w_elig;
  logic [VW-1:0]        w_rr_idx;
  logic                 w_rr_valid;
  logic                 w_lock_hit;
  logic [VW-1:0]        w_gnt_idx;
  logic                 w_gnt_valid;
  logic [VCHANNELS-1:0] w_gnt_oh;

  // Masking eligibility under reset keeps every handshake low while rst is
  // asserted, independent of what the sources present.
  assign w_elig = rst ? '0 : (in_valid & out_ready);

  noc_vc_rr_select #(
    .N (VCHANNELS),
    .W (VW)
  ) u_rr_select (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // The lock is only a preference: an ineligible locked VC falls back to the
  // round-robin pick so other VCs keep moving (no cross-VC deadlock).
  assign w_lock_hit  = (r_state == ST_LOCKED) && w_elig[r_lock_vc];
  assign w_gnt_idx   = w_lock_hit ? r_lock_vc : w_rr_idx;
  assign w_gnt_valid = w_lock_hit | w_rr_valid;

  always_comb begin
    w_gnt_oh = '0;
    out_flit = '0;
    out_last = 1'b0;
    for (int v = 0; v < VCHANNELS; v++) begin
      w_gnt_oh[v] = w_gnt_valid && (w_gnt_idx == VW'(v));
      if (w_gnt_oh[v]) begin
        out_flit = in_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
        out_last = in_last[v];
      end
    end
  end

  assign in_ready    = w_gnt_oh;
  assign out_valid   = w_gnt_oh;
  assign lock_active = (r_state == ST_LOCKED);
  assign lock_vc     = r_lock_vc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_UNLOCKED;
      r_lock_vc <= '0;
      r_rr_ptr  <= VW'(VCHANNELS - 1);
      r_cnt     <= '0;
    end else if (w_gnt_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (!out_last && (QUANTUM > 1)) begin
            r_state   <= ST_LOCKED;
            r_lock_vc <= w_gnt_idx;
            r_cnt     <= CW'(1);
          end else begin
            r_rr_ptr  <= w_gnt_idx;
          end
        end
        ST_LOCKED: begin
          // Transfers on other VCs while the locked VC stalls leave the
          // burst state untouched so the packet resumes where it stopped.
          if (w_lock_hit) begin
            if (out_last || ((r_cnt + 1'b1) == CW'(QUANTUM))) begin
              r_state  <= ST_UNLOCKED;
              r_rr_ptr <= r_lock_vc;
              r_cnt    <= '0;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

`ifdef NOC_VC_SCHED_STATS_EN
  for (genvar v = 0; v < VCHANNELS; v++) begin : g_stat_vc
    logic [STAT_W-1:0] r_flits;
    logic [STAT_W-1:0] r_stall;

    // Clear has priority over an increment in the same cycle.
    always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
        r_flits <= '0;
        r_stall <= '0;
      end else begin
        if (w_gnt_oh[v]) begin
          r_flits <= r_flits + STAT_W'(1);
        end
        if (in_valid[v] && out_ready[v] && !w_gnt_oh[v]) begin
          r_stall <= r_stall + STAT_W'(1);
        end
      end
    end

    assign stat_flits[v*STAT_W +: STAT_W] = r_flits;
    assign stat_stall[v*STAT_W +: STAT_W] = r_stall;
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule : noc_vc_link_scheduler
`default_nettype wire
